multicycle_controller: RTL and testbench

Main control FSM for the multicycle RISC-V datapath. Sequences one instruction at a time through the shared ALU, memory port, instruction register and register file, producing mux selects and write enables per cycle. Its `alu_op` drives the existing ALU decoder: 00 = add, 01 = subtract, 10 = use funct3. Supports lw, sw, R-type ALU, I-type ALU, beq/bne, jal and jalr, with a ready handshake on the unified memory port.

---
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RISC-V datapath: sequences each instruction
// through fetch/decode/execute/writeback and drives datapath selects and enables.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] alu_op,
   output logic       instr_done,
   output logic       halt,
   output logic [3:0] state
);

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 7;

   localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_STORE  = OP_W'(35);
   localparam logic [OP_W-1:0] OP_RTYPE  = OP_W'(51);
   localparam logic [OP_W-1:0] OP_ITYPE  = OP_W'(19);
   localparam logic [OP_W-1:0] OP_JAL    = OP_W'(111);
   localparam logic [OP_W-1:0] OP_JALR   = OP_W'(103);
   localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(99);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_JALR_ADR = 4'd11,
      S_JALR_JMP = 4'd12,
      S_HALT     = 4'd15
   } state_t;

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign state = STATE_W'(state_q);

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_op     = 2'b00;
      instr_done = 1'b0;
      halt       = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR_ADR;
               OP_BRANCH:         state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_HALT;
               default:           state_d = S_HALT;
            endcase
         end
         S_MEMADR, S_JALR_ADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            if (state_q == S_JALR_ADR) state_d = S_JALR_JMP;
            else                       state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req    = 1'b1;
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         // Jump target already sits in ALUOut; the ALU forms the link value oldPC+4.
         S_JAL, S_JALR_JMP: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         S_BRANCH: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            instr_done = 1'b1;
            pc_write   = (funct3 == 3'b000) ? zero : ((funct3 == 3'b001) ? ~zero : 1'b0);
            state_d    = S_FETCH;
         end
         S_HALT: begin
            halt = 1'b1;
         end
         default: state_d = S_HALT;
      endcase

      // Reset masks every side effect in the cycle it is asserted.
      if (reset) begin
         mem_req   = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one stimulus step per cycle, with the
// state code and every control output compared against hand-derived vectors.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, adr_src, ir_write, pc_write, reg_write, mem_write;
   logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
   logic       instr_done, halt;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .result_src(result_src), .alu_op(alu_op), .instr_done(instr_done),
      .halt(halt), .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mk(input logic mreq, input logic adr, input logic irw,
                                      input logic pcw, input logic rw, input logic mw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] rs, input logic [1:0] aop,
                                      input logic done, input logic hlt);
      return {mreq, adr, irw, pcw, rw, mw, a, b, rs, aop, done, hlt};
   endfunction

   logic [15:0] v_frst, v_fetch, v_fstall, v_dec, v_adr, v_mrd, v_mwb, v_mwr, v_mwr_done,
                v_mwr_rst, v_execr, v_execi, v_aluwb, v_jmp, v_br_t, v_br_n, v_halt;

   // Drive one cycle of inputs, check just after, then advance to the next falling edge.
   task automatic cyc(input string tag, input logic [6:0] o, input logic [2:0] f3,
                      input logic z, input logic mr, input logic rst,
                      input logic [3:0] es, input logic [15:0] eo);
      logic [15:0] obs;
      op = o; funct3 = f3; zero = z; mem_ready = mr; reset = rst;
      #1;
      obs = {mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
             alu_src_a, alu_src_b, result_src, alu_op, instr_done, halt};
      checks++;
      assert (state === es) else begin
         failures++;
         $error("FAIL %s state observed=%0d expected=%0d", tag, state, es);
      end
      checks++;
      assert (obs === eo) else begin
         failures++;
         $error("FAIL %s outputs observed=%04h expected=%04h", tag, obs, eo);
      end
      @(negedge clk);
   endtask

   initial begin
      v_frst     = mk(0,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 0,0);
      v_fetch    = mk(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 0,0);
      v_fstall   = mk(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 0,0);
      v_dec      = mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0);
      v_adr      = mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0);
      v_mrd      = mk(1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
      v_mwb      = mk(0,0,0,0,1,0, 2'b00,2'b00,2'b01,2'b00, 1,0);
      v_mwr      = mk(1,1,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0);
      v_mwr_done = mk(1,1,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0);
      v_mwr_rst  = mk(0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
      v_execr    = mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 0,0);
      v_execi    = mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b10, 0,0);
      v_aluwb    = mk(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 1,0);
      v_jmp      = mk(0,0,0,1,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0);
      v_br_t     = mk(0,0,0,1,0,0, 2'b10,2'b00,2'b00,2'b01, 1,0);
      v_br_n     = mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b01, 1,0);
      v_halt     = mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1);

      reset = 1'b1; op = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
      @(negedge clk);

      // Reset, then R-type
      cyc("rst0", 7'd51, 3'd0, 0, 1, 1, 4'd0, v_frst);
      cyc("rst1", 7'd51, 3'd0, 0, 1, 1, 4'd0, v_frst);
      cyc("r_fetch", 7'd51, 3'd0, 0, 1, 0, 4'd0, v_fetch);
      cyc("r_dec",   7'd51, 3'd0, 0, 1, 0, 4'd1, v_dec);
      cyc("r_exec",  7'd51, 3'd0, 0, 1, 0, 4'd6, v_execr);
      cyc("r_wb",    7'd51, 3'd0, 0, 1, 0, 4'd7, v_aluwb);

      // lw with 3 fetch stalls and 2 read stalls: 10 cycles
      for (int i = 0; i < 3; i++) cyc("lw_fstall", 7'd3, 3'd2, 0, 0, 0, 4'd0, v_fstall);
      cyc("lw_fetch", 7'd3, 3'd2, 0, 1, 0, 4'd0, v_fetch);
      cyc("lw_dec",   7'd3, 3'd2, 0, 1, 0, 4'd1, v_dec);
      cyc("lw_adr",   7'd3, 3'd2, 0, 1, 0, 4'd2, v_adr);
      for (int i = 0; i < 2; i++) cyc("lw_rstall", 7'd3, 3'd2, 0, 0, 0, 4'd3, v_mrd);
      cyc("lw_read",  7'd3, 3'd2, 0, 1, 0, 4'd3, v_mrd);
      cyc("lw_wb",    7'd3, 3'd2, 0, 1, 0, 4'd4, v_mwb);

      // sw, no stall
      cyc("sw_fetch", 7'd35, 3'd2, 0, 1, 0, 4'd0, v_fetch);
      cyc("sw_dec",   7'd35, 3'd2, 0, 1, 0, 4'd1, v_dec);
      cyc("sw_adr",   7'd35, 3'd2, 0, 1, 0, 4'd2, v_adr);
      cyc("sw_write", 7'd35, 3'd2, 0, 1, 0, 4'd5, v_mwr_done);

      // I-type
      cyc("i_fetch", 7'd19, 3'd0, 0, 1, 0, 4'd0, v_fetch);
      cyc("i_dec",   7'd19, 3'd0, 0, 1, 0, 4'd1, v_dec);
      cyc("i_exec",  7'd19, 3'd0, 0, 1, 0, 4'd8, v_execi);
      cyc("i_wb",    7'd19, 3'd0, 0, 1, 0, 4'd7, v_aluwb);

      // Branches: beq taken / not taken, bne taken / not taken
      cyc("beq1_fetch", 7'd99, 3'b000, 1, 1, 0, 4'd0, v_fetch);
      cyc("beq1_dec",   7'd99, 3'b000, 1, 1, 0, 4'd1, v_dec);
      cyc("beq1_br",    7'd99, 3'b000, 1, 1, 0, 4'd10, v_br_t);
      cyc("beq0_fetch", 7'd99, 3'b000, 0, 1, 0, 4'd0, v_fetch);
      cyc("beq0_dec",   7'd99, 3'b000, 0, 1, 0, 4'd1, v_dec);
      cyc("beq0_br",    7'd99, 3'b000, 0, 1, 0, 4'd10, v_br_n);
      cyc("bne0_fetch", 7'd99, 3'b001, 0, 1, 0, 4'd0, v_fetch);
      cyc("bne0_dec",   7'd99, 3'b001, 0, 1, 0, 4'd1, v_dec);
      cyc("bne0_br",    7'd99, 3'b001, 0, 1, 0, 4'd10, v_br_t);
      cyc("bne1_fetch", 7'd99, 3'b001, 1, 1, 0, 4'd0, v_fetch);
      cyc("bne1_dec",   7'd99, 3'b001, 1, 1, 0, 4'd1, v_dec);
      cyc("bne1_br",    7'd99, 3'b001, 1, 1, 0, 4'd10, v_br_n);

      // jal and jalr
      cyc("jal_fetch", 7'd111, 3'd0, 0, 1, 0, 4'd0, v_fetch);
      cyc("jal_dec",   7'd111, 3'd0, 0, 1, 0, 4'd1, v_dec);
      cyc("jal_jmp",   7'd111, 3'd0, 0, 1, 0, 4'd9, v_jmp);
      cyc("jal_wb",    7'd111, 3'd0, 0, 1, 0, 4'd7, v_aluwb);
      cyc("jalr_fetch", 7'd103, 3'd0, 0, 1, 0, 4'd0, v_fetch);
      cyc("jalr_dec",   7'd103, 3'd0, 0, 1, 0, 4'd1, v_dec);
      cyc("jalr_adr",   7'd103, 3'd0, 0, 1, 0, 4'd11, v_adr);
      cyc("jalr_jmp",   7'd103, 3'd0, 0, 1, 0, 4'd12, v_jmp);
      cyc("jalr_wb",    7'd103, 3'd0, 0, 1, 0, 4'd7, v_aluwb);

      // Illegal lui: HALT holds for 20 cycles, one reset cycle leaves it
      cyc("lui_fetch", 7'd55, 3'd0, 0, 1, 0, 4'd0, v_fetch);
      cyc("lui_dec",   7'd55, 3'd0, 0, 1, 0, 4'd1, v_dec);
      for (int i = 0; i < 20; i++) cyc("lui_halt", 7'd55, 3'd0, i[0], 1, 0, 4'd15, v_halt);
      cyc("lui_rst",   7'd55, 3'd0, 0, 1, 1, 4'd15, v_halt);

      // Illegal branch funct3
      cyc("bx_fetch", 7'd99, 3'b100, 0, 1, 0, 4'd0, v_fetch);
      cyc("bx_dec",   7'd99, 3'b100, 0, 1, 0, 4'd1, v_dec);
      cyc("bx_halt",  7'd99, 3'b100, 0, 1, 0, 4'd15, v_halt);
      cyc("bx_rst",   7'd99, 3'b100, 0, 1, 1, 4'd15, v_halt);

      // Reset during a store stall
      cyc("sr_fetch", 7'd35, 3'd2, 0, 1, 0, 4'd0, v_fetch);
      cyc("sr_dec",   7'd35, 3'd2, 0, 1, 0, 4'd1, v_dec);
      cyc("sr_adr",   7'd35, 3'd2, 0, 1, 0, 4'd2, v_adr);
      cyc("sr_stall", 7'd35, 3'd2, 0, 0, 0, 4'd5, v_mwr);
      cyc("sr_rst",   7'd35, 3'd2, 0, 0, 1, 4'd5, v_mwr_rst);
      cyc("sr_after", 7'd35, 3'd2, 0, 1, 0, 4'd0, v_fetch);
      cyc("sr_dec2",  7'd35, 3'd2, 0, 1, 0, 4'd1, v_dec);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
